// File: rtl/scale_mux_pkg.sv
// Shared constants for the scale_mux slice: default data width and register reset value.
package scale_mux_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MAX_WIDTH     = 64;

    // Wide enough for any legal WIDTH; users slice off the low WIDTH bits.
    localparam logic [MAX_WIDTH-1:0] RESET_VALUE = '0;

endpackage

// File: rtl/scale_mux_reg.sv
// Pipeline register for scale_mux: captures data and select every cycle, async reset.
// Adds a registered even-parity bit when SCALE_MUX_PARITY_EN is defined.
module scale_mux_reg
    import scale_mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             d_sel,
    output logic [WIDTH-1:0] q,
    output logic             q_sel
`ifdef SCALE_MUX_PARITY_EN
    ,
    output logic             q_par
`endif
);

    logic [WIDTH-1:0] q_reg;
    logic             sel_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg   <= RESET_VALUE[WIDTH-1:0];
            sel_reg <= 1'b0;
        end else begin
            q_reg   <= d;
            sel_reg <= d_sel;
        end
    end

    assign q     = q_reg;
    assign q_sel = sel_reg;

`ifdef SCALE_MUX_PARITY_EN
    logic par_reg;

    // Parity is taken from the incoming data so it lands in the same cycle as q_reg.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_reg <= 1'b0;
        end else begin
            par_reg <= ^d;
        end
    end

    assign q_par = par_reg;
`endif

endmodule

// File: rtl/scale_mux.sv
// 2:1 mux with combinational output plus a registered copy of data and select.
// Define SCALE_MUX_PARITY_EN to add the registered parity output par_q.
module scale_mux
    import scale_mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_q
`ifdef SCALE_MUX_PARITY_EN
    ,
    output logic             par_q
`endif
);

    // The conditional operator merges a and b bitwise when sel is unknown.
    assign out = sel ? b : a;

    scale_mux_reg #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clk   (clk),
        .rst   (rst),
        .d     (out),
        .d_sel (sel),
        .q     (out_q),
        .q_sel (sel_q)
`ifdef SCALE_MUX_PARITY_EN
        ,
        .q_par (par_q)
`endif
    );

endmodule

// File: tb/tb_scale_mux.sv
// Directed self-checking bench for scale_mux (WIDTH=8 main instance, WIDTH=1 instance).
// Parity checks are compiled in when SCALE_MUX_PARITY_EN is defined.
module tb_scale_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       sel = 1'b0;
    logic [7:0] out;
    logic [7:0] out_q;
    logic       sel_q;

    logic       a1 = 1'b0;
    logic       b1 = 1'b0;
    logic       sel1 = 1'b0;
    logic       out1;
    logic       out_q1;
    logic       sel_q1;

`ifdef SCALE_MUX_PARITY_EN
    logic       par_q;
    logic       par_q1;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    scale_mux #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .sel   (sel),
        .out   (out),
        .out_q (out_q),
        .sel_q (sel_q)
`ifdef SCALE_MUX_PARITY_EN
        ,
        .par_q (par_q)
`endif
    );

    scale_mux #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .a     (a1),
        .b     (b1),
        .sel   (sel1),
        .out   (out1),
        .out_q (out_q1),
        .sel_q (sel_q1)
`ifdef SCALE_MUX_PARITY_EN
        ,
        .par_q (par_q1)
`endif
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
        $display("vec %0d %s observed=%0h expected=%0h", vectors, tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] truth;

    initial begin
        // Reset state, before any clock edge.
        #1;
        check("rst_out_q", 64'(out_q), 64'h00);
        check("rst_sel_q", 64'(sel_q), 64'h0);
`ifdef SCALE_MUX_PARITY_EN
        check("rst_par_q", 64'(par_q), 64'h0);
`endif
        tick();
        check("rst_hold_out_q", 64'(out_q), 64'h00);

        @(negedge clk);
        rst = 1'b0;

        // sel=0, a=00, b=FF
        sel = 1'b0; a = 8'h00; b = 8'hFF;
        #1;
        check("s0_a00_out", 64'(out), 64'h00);
        tick();
        check("s0_a00_out_q", 64'(out_q), 64'h00);
        check("s0_a00_sel_q", 64'(sel_q), 64'h0);

        // sel=0, a=FF, b=00
        @(negedge clk);
        a = 8'hFF; b = 8'h00;
        #1;
        check("s0_aFF_out", 64'(out), 64'hFF);
        tick();
        check("s0_aFF_out_q", 64'(out_q), 64'hFF);
`ifdef SCALE_MUX_PARITY_EN
        check("s0_aFF_par_q", 64'(par_q), 64'h0);
`endif

        // sel=1, no clock between changes
        @(negedge clk);
        sel = 1'b1; a = 8'h00; b = 8'hFF;
        #1;
        check("s1_bFF_out", 64'(out), 64'hFF);
        check("s1_bFF_out_q_unchanged", 64'(out_q), 64'hFF);
        a = 8'hFF; b = 8'h00;
        #1;
        check("s1_b00_out", 64'(out), 64'h00);
        check("s1_b00_out_q_unchanged", 64'(out_q), 64'hFF);

        // sel=1, b=01
        @(negedge clk);
        b = 8'h01;
        tick();
        check("s1_b01_out_q", 64'(out_q), 64'h01);
        check("s1_b01_sel_q", 64'(sel_q), 64'h1);
`ifdef SCALE_MUX_PARITY_EN
        check("s1_b01_par_q", 64'(par_q), 64'h1);
`endif

        // Load A5, then assert reset between edges.
        @(negedge clk);
        sel = 1'b0; a = 8'hA5;
        tick();
        check("a5_out_q", 64'(out_q), 64'hA5);
        check("a5_sel_q", 64'(sel_q), 64'h0);
        @(negedge clk);
        sel = 1'b1; b = 8'h7E;
        tick();
        check("7e_sel_q", 64'(sel_q), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_q", 64'(out_q), 64'h00);
        check("midrst_sel_q", 64'(sel_q), 64'h0);
        check("midrst_out", 64'(out), 64'h7E);
        b = 8'h3C;
        #1;
        check("midrst_out_follows", 64'(out), 64'h3C);
        tick();
        check("rst_edge_out_q", 64'(out_q), 64'h00);

        // First edge after release loads current value.
        @(negedge clk);
        rst = 1'b0;
        b = 8'h5A;
        tick();
        check("post_rst_out_q", 64'(out_q), 64'h5A);
        check("post_rst_sel_q", 64'(sel_q), 64'h1);
`ifdef SCALE_MUX_PARITY_EN
        check("post_rst_par_q", 64'(par_q), 64'h0);
`endif

        // WIDTH=1 exhaustive, index {sel,a,b}.
        truth = 8'b1010_1100;
        for (int i = 0; i < 8; i++) begin
            sel1 = i[2]; a1 = i[1]; b1 = i[0];
            #1;
            check($sformatf("w1_out_%0d", i), 64'(out1), 64'(truth[i]));
        end
        @(negedge clk);
        sel1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
        tick();
        check("w1_out_q", 64'(out_q1), 64'h1);
        check("w1_sel_q", 64'(sel_q1), 64'h1);
`ifdef SCALE_MUX_PARITY_EN
        check("w1_par_q", 64'(par_q1), 64'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/scale_mux.md
SCALE_MUX -- requirements
Module: scale_mux

Interface
REQ-001 Parameter WIDTH, default 8: bit width of both data inputs and all data outputs; legal range 1..64.
REQ-002 clk  input  1  single clock; all registered state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 a  input  WIDTH  data input selected when sel=0.
REQ-005 b  input  WIDTH  data input selected when sel=1.
REQ-006 sel  input  1  select: 0 picks a, 1 picks b.
REQ-007 out  output  WIDTH  combinational mux result.
REQ-008 out_q  output  WIDTH  registered copy of out.
REQ-009 sel_q  output  1  registered copy of sel, aligned with out_q.
REQ-010 par_q  output  1  even parity (XOR of all bits) of out_q; present only when SCALE_MUX_PARITY_EN is defined.

Function
REQ-011 out SHALL equal a when sel=0 and b when sel=1, bit for bit, with zero clock latency.
REQ-012 out SHALL update within the same delta/time step as any change on a, b or sel, independent of clk and rst.
REQ-013 out SHALL NOT be affected by rst.
REQ-014 sel X/Z: each out bit SHALL be the known value where a and b agree, otherwise X.
REQ-015 out_q and sel_q SHALL capture out and sel on every rising clk edge while rst=0; latency exactly 1 cycle.
REQ-016 No enable or handshake; the registers load every cycle.
REQ-017 par_q SHALL be registered in the same cycle as out_q, so it always matches the current out_q.
REQ-018 WIDTH=1 SHALL behave identically to a 1-bit 2:1 mux with no special casing.

Reset
REQ-019 While rst=1: out_q SHALL be all zeros, sel_q SHALL be 0, and par_q SHALL be 0, immediately and without waiting for clk.
REQ-020 Reset asserted mid-operation SHALL clear the registers within the same time step.
REQ-021 On the first rising clk edge after rst falls, the registers SHALL load the current out/sel.
REQ-022 Deassertion of rst coincident with a clk edge: that edge SHALL NOT load the registers.

Configuration
REQ-023 Macro SCALE_MUX_PARITY_EN defined: the par_q port and parity register exist.
REQ-024 Macro SCALE_MUX_PARITY_EN undefined: no par_q port and no parity logic; all other behaviour is identical.

Structure
REQ-025 A shared package scale_mux_pkg SHALL hold the DEFAULT_WIDTH=8 constant and the reset-value constant (all zeros).
REQ-026 A single leaf sub-module scale_mux_reg SHALL implement the WIDTH+1-bit async-reset pipeline register, plus the parity bit when enabled.
REQ-027 The top level contains only the combinational select and the scale_mux_reg instance.

Verification (WIDTH=8)
REQ-028 sel=0, a=8'h00, b=8'hFF -> out=8'h00; after the next clk edge, out_q=8'h00 and sel_q=0.
REQ-029 sel=0, a=8'hFF, b=8'h00 -> out=8'hFF; next edge -> out_q=8'hFF; par_q=0 when enabled.
REQ-030 sel=1, a=8'h00, b=8'hFF -> out=8'hFF; sel=1, a=8'hFF, b=8'h00 -> out=8'h00; no clock is needed for out to change.
REQ-031 out_q=8'hA5, then rst=1 between clk edges -> out_q=8'h00 and sel_q=0 immediately; out still follows a/b/sel.
REQ-032 sel=1, b=8'h01 -> next edge out_q=8'h01 and par_q=1; rebuild without SCALE_MUX_PARITY_EN -> port absent, other results unchanged.
REQ-033 WIDTH=1, all 8 combinations of sel/a/b -> out matches the REQ-011 truth table exhaustively.
